uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
- Accepts bytes over a per-requester valid/ready handshake.
- Gates every new byte on the synchronized peer CTS line.
- Drives the transmitter's start/byte inputs and tracks its busy flag.
- Sits between producers (keypad, counters, status) and UART_TX, in the 12 MHz hwclk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
STALL_CYCLES, 120000, consecutive cycles of CTS low with pending requests before stall asserts (10 ms at 12 MHz).
ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).

Ports:
hwclk  in  1  system clock, 12 MHz.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester byte valid.
req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
req_last  in  NUM_REQ  last byte of a packet; used only with UART_ARB_PKT_LOCK_EN.
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
cts  in  1  peer clear-to-send, asynchronous, high = peer may receive.
tx_data  out  8  byte presented to the transmitter.
tx_start  out  1  start request to the transmitter.
tx_busy  in  1  transmitter busy (high from accepted start through stop bit).
grant_id  out  ID_W  index of the last granted requester.
stall  out  1  flow-control stall flag.

Behaviour:
Reset values:
- req_ready=0, tx_start=0, tx_data=8'h00, grant_id=NUM_REQ-1, stall=0, state=IDLE.
- Round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first.

CTS synchronizer:
- 2-FF synchronizer on cts gives cts_s, 2 cycles of latency.
- Both sync flops reset to 0.

FSM states: IDLE, START, WAIT_DONE.
- IDLE: if any req_valid=1 and cts_s=1:
  - Pick the first valid requester searching upward from grant_id+1, wrapping modulo NUM_REQ.
  - Assert req_ready for that requester only, for that single cycle.
  - Latch its byte into tx_data, update grant_id, go to START.
  - If cts_s=0 or no request is valid, stay in IDLE.
- START: hold tx_start=1 until tx_busy=1 is sampled, then drop tx_start and go to WAIT_DONE.
  - Covers a transmitter that samples start only on its baud tick.
- WAIT_DONE: when tx_busy=0, go to IDLE.
- Minimum byte-to-byte gap: one IDLE cycle after busy falls. The next grant occurs in that cycle.

Handshake rules:
- A byte is transferred on the cycle where req_valid[i] and req_ready[i] are both 1.
- A requester must hold req_valid and req_data stable until it sees req_ready.
- tx_data stays stable from the grant until the next grant.

Simultaneous events and boundaries:
- All requesters valid: grants rotate i, i+1, … with no starvation. Each requester waits at most NUM_REQ-1 bytes.
- Single requester continuously valid: it is granted every byte.
- CTS falls mid-byte: the current byte completes, and no new grant is made until cts_s=1. CTS is evaluated only in IDLE.
- tx_busy already high on entry to START: leave START after 1 cycle.

Stall flag:
- A saturating counter counts cycles with cts_s=0 and any req_valid=1.
- Any other cycle clears it to 0.
- stall=1 while counter ≥ STALL_CYCLES; it clears the cycle after cts_s=1.
- Counter width is clog2(STALL_CYCLES+1).

Reset mid-operation:
- Returns to IDLE next edge and drops tx_start.
- A byte already latched but not yet started is discarded.
- The transmitter finishes any byte already in flight on its own.

Optional Feature:
UART_ARB_PKT_LOCK_EN
- Defined: packet lock. After granting requester i with req_last[i]=0, IDLE grants only requester i until a byte with req_last=1 is accepted.
  - While locked, other requesters are ignored even if requester i is not valid.
  - Reset clears the lock.
- Undefined: req_last is ignored, and arbitration is per byte.

Decomposition:
Shared package uart_pkg:
- FSM state encoding (IDLE/START/WAIT_DONE).
- Byte width constant UART_DATA_W=8.
- Default STALL_CYCLES and the hwclk frequency constant 12_000_000.

Sub-module rr_picker:
- Combinational round-robin priority search.
- Inputs: req vector, last grant. Outputs: one-hot grant and index.
- Reusable by other shared-resource blocks.

Test Plan:
1. Reset, cts=1, req_valid=4'b0001 with 8'h30 → req_ready[0] pulses 1 cycle; tx_data=8'h30; tx_start=1 until the model raises busy; grant_id=0.
2. All four valid with 8'h41..8'h44, transmitter model busy for 10 cycles per byte → transmitted order is 0,1,2,3,0; exactly one req_ready per byte; 1-cycle IDLE gap between bytes.
3. cts=0 with req_valid=4'b0100 for 120002 cycles → no req_ready; stall=1 from the cycle the counter reaches 120000. Then cts=1 → stall=0 after the sync delay; requester 2 is granted.
4. Drop cts while byte 8'h55 is busy → byte completes; no further tx_start until cts is high again for 2 cycles.
5. Assert rst while in START → tx_start=0 and req_ready=0 next edge; grant_id=3. Then with requesters 0 and 2 valid, requester 0 is granted first.
6. With UART_ARB_PKT_LOCK_EN: requester 1 sends 3 bytes, last flagged on byte 3, while requester 0 is continuously valid → bytes 1,1,1 are sent, then requester 0. Without the macro → order is 1,0,1,0…

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, clock constants and the
// transmit arbiter FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int HWCLK_HZ             = 12_000_000;
  // 10 ms of CTS-low at HWCLK_HZ
  localparam int DEFAULT_STALL_CYCLES = 120_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority search.
//   req  : request vector
//   last : index of the previous grant; search starts at last+1, wraps mod N
//   gnt  : one-hot grant (all zero when no request)
//   idx  : index of the granted request (equals last when none)
//   any  : at least one request present
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned     pos;
  logic [ID_W-1:0] pos_idx;

  always_comb begin
    gnt     = '0;
    idx     = last;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos     = (int'(last) + k) % N;
      pos_idx = ID_W'(pos);
      if (!any && req[pos_idx]) begin
        any          = 1'b1;
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers, gated by the synchronized peer CTS line.
//   hwclk, rst            : 12 MHz clock, synchronous active-high reset
//   req_valid/req_data    : per-requester byte offer (requester i in [8i+7:8i])
//   req_last              : last byte of a packet (packet lock only)
//   req_ready             : one-hot, one-cycle accept pulse
//   cts                   : asynchronous peer clear-to-send
//   tx_data/tx_start      : byte and start request to the transmitter
//   tx_busy               : transmitter busy
//   grant_id              : index of the last granted requester
//   stall                 : CTS held low with pending requests for STALL_CYCLES
// Build option UART_ARB_PKT_LOCK_EN: once a requester is granted a byte
// without req_last, only that requester is served until its last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES,
  parameter int ID_W         = 2
) (
  input  logic                           hwclk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           cts,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           stall
);

  localparam int              CNT_W     = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
  logic [UART_DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic [ID_W-1:0]          grant_id_q, grant_id_d;
  logic                     stall_q, stall_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic                     cts_meta_q, cts_s_q;

  logic [NUM_REQ-1:0]       pick_req, pick_gnt;
  logic [ID_W-1:0]          pick_idx;
  logic                     pick_any;
  logic [UART_DATA_W-1:0]   pick_data;

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q, lock_d;

  // While locked, only the last granted requester is visible to the picker.
  assign pick_req = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id_q)) : req_valid;
`else
  logic unused_req_last;

  assign unused_req_last = ^req_last;
  assign pick_req        = req_valid;
`endif

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_picker (
    .req  (pick_req),
    .last (grant_id_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_data = req_data[i*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_data_d   = tx_data_q;
    tx_start_d  = tx_start_q;
    grant_id_d  = grant_id_q;
`ifdef UART_ARB_PKT_LOCK_EN
    lock_d      = lock_q;
`endif

    unique case (state_q)
      IDLE: begin
        // CTS is only consulted here, so a byte in flight always completes.
        if (pick_any && cts_s_q) begin
          req_ready_d = pick_gnt;
          tx_data_d   = pick_data;
          grant_id_d  = pick_idx;
          tx_start_d  = 1'b1;
          state_d     = START;
`ifdef UART_ARB_PKT_LOCK_EN
          lock_d      = !req_last[pick_idx];
`endif
        end
      end
      START: begin
        // Start is held until the transmitter acknowledges with busy.
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    if (!cts_s_q && (|req_valid)) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = '0;
    end
    stall_d = (stall_cnt_d >= STALL_MAX);
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      grant_id_q  <= LAST_ID;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      cts_meta_q  <= 1'b0;
      cts_s_q     <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      grant_id_q  <= grant_id_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      cts_meta_q  <= cts;
      cts_s_q     <= cts_meta_q;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_id_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a queue-based
// producer/transmitter environment and a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int STALL = 40;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } item_t;

  logic             hwclk     = 1'b0;
  logic             rst       = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data  = '0;
  logic [N-1:0]     req_last  = '0;
  logic [N-1:0]     req_ready;
  logic             cts       = 1'b1;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy   = 1'b0;
  logic [ID_W-1:0]  grant_id;
  logic             stall;

  always #5 hwclk = ~hwclk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .STALL_CYCLES (STALL),
    .ID_W         (ID_W)
  ) dut (
    .hwclk     (hwclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .cts       (cts),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .stall     (stall)
  );

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Environment state
  item_t      pq[N][$];
  logic [7:0] granted_q[$];
  logic [7:0] log_q[$];
  int         busy_len    = 10;
  int         start_delay = 0;
  int         tm_left     = 0;
  int         tm_wait     = 0;

  // Reference model state
  int           model_last  = N - 1;
  logic         locked      = 1'b0;
  int           lock_id     = 0;
  int           stall_cnt_m = 0;
  logic         m_s1        = 1'b0;
  logic         m_s2        = 1'b0;
  logic         ctss        = 1'b0;
  logic         snap_rst    = 1'b1;
  logic         snap_busy   = 1'b0;
  logic [N-1:0] snap_valid  = '0;
  logic [N-1:0] snap_last   = '0;
  logic [8*N-1:0] snap_data = '0;
  logic         tx_start_prev = 1'b0;
  int           wait_cnt    = 0;

  // Capture what the DUT sees at each active edge.
  always @(posedge hwclk) begin
    snap_rst   = rst;
    snap_busy  = tx_busy;
    snap_valid = req_valid;
    snap_last  = req_last;
    snap_data  = req_data;
    ctss       = m_s2;
    if (rst) begin
      m_s1        = 1'b0;
      m_s2        = 1'b0;
      stall_cnt_m = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = cts;
      if (!ctss && (|req_valid)) begin
        if (stall_cnt_m < STALL) stall_cnt_m++;
      end else begin
        stall_cnt_m = 0;
      end
    end
  end

  // Check outputs, then advance transmitter and producers.
  always @(negedge hwclk) begin
    logic [N-1:0] elig_v;
    int           exp_i;
    logic [7:0]   exp_b;

    if (snap_rst) begin
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_start", tx_start, 0);
      check_eq("rst_data", tx_data, 0);
      check_eq("rst_grant_id", grant_id, N - 1);
      check_eq("rst_stall", stall, 0);
      model_last = N - 1;
      locked     = 1'b0;
      wait_cnt   = 0;
      granted_q.delete();
    end else begin
      check_eq("stall", stall, (stall_cnt_m >= STALL));
      check_eq("ready_onehot", $onehot0(req_ready), 1);
      elig_v = locked ? (snap_valid & (N'(1) << lock_id)) : snap_valid;
      if (req_ready != '0) begin
        exp_i = rr_pick(model_last, elig_v);
        check_eq("grant_cts", ctss, 1);
        check_eq("grant_gap", (wait_cnt <= 1), 1);
        check_eq("grant_ready", req_ready, (exp_i < 0) ? 0 : (1 << exp_i));
        if (exp_i >= 0) begin
          check_eq("grant_data", tx_data, snap_data[exp_i*8 +: 8]);
          check_eq("grant_id", grant_id, exp_i);
          model_last = exp_i;
          granted_q.push_back(snap_data[exp_i*8 +: 8]);
`ifdef UART_ARB_PKT_LOCK_EN
          locked  = !snap_last[exp_i];
          lock_id = exp_i;
`endif
        end
        for (int i = 0; i < N; i++) begin
          if (req_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        wait_cnt = 0;
      end else if (ctss && (elig_v != '0) && !tx_start_prev && !snap_busy) begin
        wait_cnt++;
        if (wait_cnt == 2) check_eq("grant_late", wait_cnt, 1);
      end
      if (snap_busy) check_eq("start_drop", tx_start, 0);
    end
    tx_start_prev = tx_start;

    // Transmitter: accepts start after start_delay cycles, busy busy_len cycles.
    if (tm_left > 0) begin
      tm_left--;
      if (tm_left == 0) tx_busy = 1'b0;
    end else if (tx_start) begin
      if (tm_wait >= start_delay) begin
        tx_busy = 1'b1;
        tm_left = busy_len;
        tm_wait = 0;
        check_eq("tx_pending", granted_q.size(), 1);
        exp_b = (granted_q.size() > 0) ? granted_q.pop_front() : 8'h00;
        check_eq("tx_byte", tx_data, exp_b);
        log_q.push_back(tx_data);
      end else begin
        tm_wait++;
      end
    end else begin
      tm_wait = 0;
    end

    // Producers hold valid/data until accepted.
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pq[i].size() > 0);
      if (pq[i].size() > 0) begin
        req_data[i*8 +: 8] = pq[i][0].data;
        req_last[i]        = pq[i][0].last;
      end else begin
        req_last[i] = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hwclk);
    #2;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    item_t it;
    it.last = l;
    it.data = d;
    pq[i].push_back(it);
  endtask

  function automatic logic pending();
    logic p;
    p = tx_busy || tx_start || (granted_q.size() > 0);
    for (int i = 0; i < N; i++) p = p || (pq[i].size() > 0);
    return p;
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    tick(1);
    while (pending() && c < budget) begin
      tick(1);
      c++;
    end
    check_eq("drain_done", pending(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] log_at_end(input int back);
    return (log_q.size() > back) ? log_q[log_q.size()-1-back] : 8'hxx;
  endfunction

  initial begin
    int c;
    int base;
    logic [7:0] exp6[6];

    // 1: single byte from requester 0
    cts = 1'b1;
    tick(3);
    rst = 1'b0;
    start_delay = 3;
    push(0, 8'h30, 1'b1);
    c = 0;
    while (req_ready == '0 && c < 20) begin tick(1); c++; end
    check_eq("t1_ready", req_ready, 4'b0001);
    tick(1);
    check_eq("t1_ready_pulse", req_ready, 0);
    check_eq("t1_tx_data", tx_data, 8'h30);
    check_eq("t1_tx_start", tx_start, 1);
    check_eq("t1_grant_id", grant_id, 0);
    drain(200);
    check_eq("t1_byte", log_at_end(0), 8'h30);

    // 2: all four valid from reset, rotation 0,1,2,3,0
    start_delay = 0;
    busy_len    = 10;
    do_reset(2);
    base = log_q.size();
    for (int i = 0; i < N; i++) push(i, 8'h41 + 8'(i), 1'b1);
    push(0, 8'h45, 1'b1);
    drain(400);
    check_eq("t2_count", log_q.size() - base, 5);
    for (int k = 0; k < 5; k++) check_eq("t2_order", log_at_end(4 - k), 8'h41 + 8'(k));

    // 3: CTS low with a pending request raises stall
    cts = 1'b0;
    tick(3);
    base = log_q.size();
    push(2, 8'h66, 1'b1);
    tick(STALL + 4);
    check_eq("t3_stall", stall, 1);
    check_eq("t3_no_tx", log_q.size() - base, 0);
    check_eq("t3_no_ready", req_ready, 0);
    cts = 1'b1;
    tick(3);
    check_eq("t3_stall_clear", stall, 0);
    drain(200);
    check_eq("t3_byte", log_at_end(0), 8'h66);

    // 4: CTS drops while a byte is in flight
    push(1, 8'h55, 1'b1);
    c = 0;
    while (!tx_busy && c < 50) begin tick(1); c++; end
    check_eq("t4_busy", tx_busy, 1);
    cts = 1'b0;
    push(1, 8'h56, 1'b1);
    tick(busy_len + 10);
    check_eq("t4_held", log_at_end(0), 8'h55);
    check_eq("t4_no_start", tx_start, 0);
    cts = 1'b1;
    drain(200);
    check_eq("t4_byte", log_at_end(0), 8'h56);

    // 5: reset while in START discards the latched byte
    start_delay = 20;
    push(1, 8'h77, 1'b1);
    c = 0;
    while (!tx_start && c < 50) begin tick(1); c++; end
    check_eq("t5_in_start", tx_start, 1);
    rst = 1'b1;
    tick(1);
    check_eq("t5_start_drop", tx_start, 0);
    check_eq("t5_ready", req_ready, 0);
    check_eq("t5_grant_id", grant_id, 3);
    rst = 1'b0;
    start_delay = 0;
    base = log_q.size();
    push(0, 8'h88, 1'b1);
    push(2, 8'h99, 1'b1);
    drain(300);
    check_eq("t5_count", log_q.size() - base, 2);
    check_eq("t5_first", log_at_end(1), 8'h88);
    check_eq("t5_second", log_at_end(0), 8'h99);

    // 6: packet from requester 1 against a continuously valid requester 0
    do_reset(2);
    base = log_q.size();
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    tick(4);
    push(0, 8'hB1, 1'b1);
    push(0, 8'hB2, 1'b1);
    push(0, 8'hB3, 1'b1);
    drain(500);
`ifdef UART_ARB_PKT_LOCK_EN
    exp6 = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
`else
    exp6 = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
`endif
    check_eq("t6_count", log_q.size() - base, 6);
    for (int k = 0; k < 6; k++) check_eq("t6_order", log_at_end(5 - k), exp6[k]);

    // Randomized traffic, CTS toggling and transmitter timing
    for (int it = 0; it < 1500; it++) begin
      tick(1);
      if ($urandom_range(3) == 0) begin
        push(int'($urandom_range(N - 1)), 8'($urandom), ($urandom_range(2) == 0));
      end
      if ($urandom_range(30) == 0) cts = ~cts;
      busy_len    = int'($urandom_range(12, 1));
      start_delay = int'($urandom_range(3));
    end
    cts = 1'b1;
    for (int i = 0; i < N; i++) push(i, 8'($urandom), 1'b1);
    drain(8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

endmodule
